// File: rtl/truth_table_sweeper_if.sv
// Stimulus/response and result signals between the truth-table sweeper and
// the block it is exercising.
interface truth_table_sweeper_if;
  logic        start;
  logic        A;
  logic        B;
  logic        C;
  logic        D;
  logic        F;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] table_out;
  logic [4:0]  mismatch_cnt;
  logic [3:0]  first_fail_idx;
  logic        first_fail_valid;

  modport slave (
    input  start, F,
    output A, B, C, D, busy, done, pass,
           table_out, mismatch_cnt, first_fail_idx, first_fail_valid
  );

  modport master (
    output start, F,
    input  A, B, C, D, busy, done, pass,
           table_out, mismatch_cnt, first_fail_idx, first_fail_valid
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks {A,B,C,D} through all 16 vectors, samples F after a settle window,
// and compares the captured truth table against EXPECTED.
//
// state  | meaning
// IDLE   | waiting for start; previous results held
// SETTLE | vector applied, waiting SETTLE_CYCLES for F to settle
// SAMPLE | capture F for the current vector and score it
// DONE   | one-cycle completion pulse, results valid
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [15:0] EXPECTED      = 16'h2F22
) (
  input  logic                   clk,
  input  logic                   rst,
  truth_table_sweeper_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  vec_q, vec_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [15:0] table_q, table_d;
  logic [4:0]  mcnt_q, mcnt_d;
  logic [3:0]  ffi_q, ffi_d;
  logic        ffv_q, ffv_d;
  logic        f_bad;

  assign f_bad = (bus.F != EXPECTED[vec_q]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= 4'd0;
      cnt_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      table_q <= 16'd0;
      mcnt_q  <= 5'd0;
      ffi_q   <= 4'd0;
      ffv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      table_q <= table_d;
      mcnt_q  <= mcnt_d;
      ffi_q   <= ffi_d;
      ffv_q   <= ffv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    table_d = table_q;
    mcnt_d  = mcnt_q;
    ffi_d   = ffi_q;
    ffv_d   = ffv_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          vec_d   = 4'd0;
          busy_d  = 1'b1;
          table_d = 16'd0;
          mcnt_d  = 5'd0;
          ffi_d   = 4'd0;
          ffv_d   = 1'b0;
          pass_d  = 1'b0;
          cnt_d   = 8'd0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = 8'd0;
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SAMPLE: begin
        table_d[vec_q] = bus.F;
        if (f_bad) begin
          mcnt_d = mcnt_q + 5'd1;
          if (!ffv_q) begin
            ffi_d = vec_q;
            ffv_d = 1'b1;
          end
        end
        // Results are settled on entry to DONE so they are valid alongside the pulse.
        if (vec_q == 4'd15) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (mcnt_d == 5'd0);
        end else begin
          vec_d   = vec_q + 4'd1;
          state_d = SETTLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.A                = vec_q[3];
  assign bus.B                = vec_q[2];
  assign bus.C                = vec_q[1];
  assign bus.D                = vec_q[0];
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.pass             = pass_q;
  assign bus.table_out        = table_q;
  assign bus.mismatch_cnt     = mcnt_q;
  assign bus.first_fail_idx   = ffi_q;
  assign bus.first_fail_valid = ffv_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: vector table over several F behaviours plus
// hand-written sequences for ignored start, mid-sweep reset and held start.
module tb_truth_table_sweeper;

  typedef struct packed {
    logic [15:0] tbl;
    logic [4:0]  mcnt;
    logic [3:0]  ffi;
    logic        ffv;
    logic        pass;
  } result_t;

  typedef struct {
    int      mode;
    result_t exp;
  } vec_rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   mode0 = 0;
  int   mode1 = 0;
  int   checks = 0;
  int   errors = 0;
  result_t exp_q[$];

  truth_table_sweeper_if if0 ();
  truth_table_sweeper_if if1 ();

  truth_table_sweeper #(.SETTLE_CYCLES(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  truth_table_sweeper #(.SETTLE_CYCLES(3)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  always #5 clk = ~clk;

  // 0 correct, 1 tied 0, 2 tied 1, 3 inverted, 4 correct except vector 15
  function automatic logic fmodel(input int mode, input logic [3:0] v);
    logic good;
    good = (v[3] & ~v[2]) | (~v[1] & v[0]);
    case (mode)
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return ~good;
      4:       return good ^ (v == 4'd15);
      default: return good;
    endcase
  endfunction

  logic [3:0] vec0, vec1;
  assign vec0  = {if0.A, if0.B, if0.C, if0.D};
  assign vec1  = {if1.A, if1.B, if1.C, if1.D};
  assign if0.F = fmodel(mode0, vec0);
  assign if1.F = fmodel(mode1, vec1);

  function automatic logic [3:0] get_vec(input int sel);
    return (sel == 0) ? vec0 : vec1;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? if0.busy : if1.busy;
  endfunction

  function automatic logic get_done(input int sel);
    return (sel == 0) ? if0.done : if1.done;
  endfunction

  function automatic result_t get_res(input int sel);
    result_t r;
    if (sel == 0) r = {if0.table_out, if0.mismatch_cnt, if0.first_fail_idx, if0.first_fail_valid, if0.pass};
    else          r = {if1.table_out, if1.mismatch_cnt, if1.first_fail_idx, if1.first_fail_valid, if1.pass};
    return r;
  endfunction

  task automatic drive_start(input int sel, input logic v);
    if (sel == 0) if0.start = v;
    else          if1.start = v;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_res(input string tag, input result_t act, input result_t exp);
    chk({tag, " table_out"}, 32'(act.tbl), 32'(exp.tbl));
    chk({tag, " mismatch_cnt"}, 32'(act.mcnt), 32'(exp.mcnt));
    chk({tag, " first_fail_idx"}, 32'(act.ffi), 32'(exp.ffi));
    chk({tag, " first_fail_valid"}, 32'(act.ffv), 32'(exp.ffv));
    chk({tag, " pass"}, 32'(act.pass), 32'(exp.pass));
  endtask

  // Called just before the negedge of sweep cycle m_first; returns at the negedge of the done cycle.
  task automatic watch(input string tag, input int sel, input int settle, input int pulse_m, input int m_first);
    int      per;
    int      done_m;
    int      seq_bad;
    int      busy_bad;
    result_t e;
    per      = 16 * (settle + 1);
    done_m   = -1;
    seq_bad  = 0;
    busy_bad = 0;
    for (int m = m_first; m < per + 8; m++) begin
      @(negedge clk);
      if (m < per) begin
        if (get_vec(sel) !== 4'(m / (settle + 1))) seq_bad++;
        if (get_busy(sel) !== 1'b1) busy_bad++;
      end
      if (pulse_m >= 0 && m == pulse_m) drive_start(sel, 1'b1);
      if (pulse_m >= 0 && m == pulse_m + 1) drive_start(sel, 1'b0);
      if (get_done(sel) === 1'b1) begin
        done_m = m;
        break;
      end
    end
    chk({tag, " done latency"}, 32'(done_m), 32'(per));
    chk({tag, " vector order/hold"}, 32'(seq_bad), 32'd0);
    chk({tag, " busy during sweep"}, 32'(busy_bad), 32'd0);
    if (exp_q.size() == 0) begin
      chk({tag, " scoreboard entry present"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk_res(tag, get_res(sel), e);
    end
  endtask

  task automatic run_sweep(input string tag, input int sel, input int settle, input int pulse_m, input result_t e);
    exp_q.push_back(e);
    @(negedge clk);
    drive_start(sel, 1'b1);
    @(posedge clk);
    #1;
    drive_start(sel, 1'b0);
    watch(tag, sel, settle, pulse_m, 0);
  endtask

  vec_rec_t vecs[5];
  result_t  r_good;
  result_t  r_tie0;
  int       cnt;

  initial begin
    if0.start = 1'b0;
    if1.start = 1'b0;
    r_good = {16'h2F22, 5'd0, 4'd0, 1'b0, 1'b1};
    r_tie0 = {16'h0000, 5'd7, 4'd1, 1'b1, 1'b0};
    vecs[0] = '{mode: 0, exp: r_good};
    vecs[1] = '{mode: 1, exp: r_tie0};
    vecs[2] = '{mode: 2, exp: {16'hFFFF, 5'd9,  4'd0,  1'b1, 1'b0}};
    vecs[3] = '{mode: 3, exp: {16'hD0DD, 5'd16, 4'd0,  1'b1, 1'b0}};
    vecs[4] = '{mode: 4, exp: {16'hAF22, 5'd1,  4'd15, 1'b1, 1'b0}};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset vector", 32'(vec0), 32'd0);
    chk("reset busy", 32'(if0.busy), 32'd0);
    chk("reset done", 32'(if0.done), 32'd0);
    chk_res("reset", get_res(0), '0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      mode0 = vecs[i].mode;
      run_sweep($sformatf("vec%0d", i), 0, 1, -1, vecs[i].exp);
      @(negedge clk);
      chk($sformatf("vec%0d done single cycle", i), 32'(if0.done), 32'd0);
      repeat (2) @(negedge clk);
      chk($sformatf("vec%0d idle busy", i), 32'(if0.busy), 32'd0);
      chk($sformatf("vec%0d results held", i), 32'(if0.table_out), 32'(vecs[i].exp.tbl));
    end

    // Longer settle window; a start pulse mid-sweep must be ignored.
    mode1 = 0;
    run_sweep("settle3", 1, 3, 10, r_good);
    cnt = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (if1.done === 1'b1) cnt++;
    end
    chk("settle3 extra done pulses", 32'(cnt), 32'd0);

    // Reset while vector 6 is applied.
    mode0 = 0;
    @(negedge clk);
    if0.start = 1'b1;
    @(posedge clk);
    #1;
    if0.start = 1'b0;
    cnt = 0;
    while (vec0 !== 4'd6 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("reached vector 6", 32'(vec0), 32'd6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset busy", 32'(if0.busy), 32'd0);
    chk("midreset vector", 32'(vec0), 32'd0);
    chk("midreset table_out", 32'(if0.table_out), 32'd0);
    chk("midreset mismatch_cnt", 32'(if0.mismatch_cnt), 32'd0);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (if0.done === 1'b1) cnt++;
      @(negedge clk);
    end
    chk("midreset no done", 32'(cnt), 32'd0);
    run_sweep("after reset", 0, 1, -1, r_good);

    // start held high across two back-to-back sweeps.
    repeat (2) @(negedge clk);
    mode0 = 1;
    exp_q.push_back(r_tie0);
    if0.start = 1'b1;
    @(posedge clk);
    #1;
    watch("held1", 0, 1, -1, 0);
    mode0 = 0;
    exp_q.push_back(r_good);
    @(negedge clk);
    chk("held gap busy", 32'(if0.busy), 32'd0);
    chk("held gap table_out", 32'(if0.table_out), 32'h0000);
    chk("held gap mismatch_cnt", 32'(if0.mismatch_cnt), 32'd7);
    @(negedge clk);
    chk("held restart busy", 32'(if0.busy), 32'd1);
    chk("held restart vector", 32'(vec0), 32'd0);
    chk("held restart mismatch_cnt", 32'(if0.mismatch_cnt), 32'd0);
    chk("held restart first_fail_valid", 32'(if0.first_fail_valid), 32'd0);
    watch("held2", 0, 1, -1, 1);
    if0.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("held end busy", 32'(if0.busy), 32'd0);
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential stimulus-and-check stage wrapped around the 4-input combinational function F = A·B' + C'·D.
- Upstream role: drives A, B, C, D through all 16 input combinations in ascending order.
- Downstream role: samples the returned F for each vector, assembles a 16-bit truth-table word and compares it bit-for-bit against an expected word.
- Reports pass/fail, the mismatch count and the first failing index. Used for self-checking synthesisable regression of the combinational designs.

Parameters:
- SETTLE_CYCLES, 1, cycles each vector is held before F is sampled; legal range 1..255.
- EXPECTED, 16'h2F22, golden truth table; bit i = required F for {A,B,C,D} = i. Default encodes minterms 1, 5, 8, 9, 10, 11, 13.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- A  output  1  vector bit 3 (MSB), registered.
- B  output  1  vector bit 2, registered.
- C  output  1  vector bit 1, registered.
- D  output  1  vector bit 0 (LSB), registered.
- F  input  1  response of the design under check; combinational from A..D.
- busy  output  1  high while a sweep is in progress.
- done  output  1  single-cycle pulse at sweep end.
- pass  output  1  high when the last completed sweep had zero mismatches.
- table_out  output  16  captured truth table; bit i = F sampled at vector i.
- mismatch_cnt  output  5  number of vectors where F != EXPECTED[i] (0..16).
- first_fail_idx  output  4  index of the lowest mismatching vector.
- first_fail_valid  output  1  high when first_fail_idx is meaningful.

Behaviour:
- Interface decided: one clock, clk; reset rst is synchronous and active-high. All state and outputs are registered.
- Reset values:
  - state = IDLE.
  - {A,B,C,D} = 0.
  - busy, done, pass = 0.
  - table_out = 0, mismatch_cnt = 0.
  - first_fail_idx = 0, first_fail_valid = 0.
  - Settle counter = 0.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 at edge k: vec <= 0, busy <= 1; clear table_out, mismatch_cnt, first_fail_valid, first_fail_idx and pass; cnt <= 0; go to SETTLE.
  - start=0: hold. Results of the previous sweep remain stable.
- SETTLE:
  - cnt increments each cycle.
  - When cnt == SETTLE_CYCLES-1: cnt <= 0, go to SAMPLE.
  - {A,B,C,D} is stable for the whole of SETTLE and SAMPLE.
- SAMPLE:
  - table_out[vec] <= F.
  - If F != EXPECTED[vec]:
    - mismatch_cnt increments.
    - If first_fail_valid == 0: first_fail_idx <= vec and first_fail_valid <= 1.
  - If vec == 15: go to DONE, vec stays 15.
  - Otherwise: vec <= vec+1, go to SETTLE.
- DONE:
  - done = 1 for exactly this cycle; busy <= 0.
  - pass <= (final mismatch_cnt == 0).
  - Next state IDLE.
- Timing:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - done is high in the cycle following edge k + 16*(SETTLE_CYCLES+1); with the default, 32 cycles after the start edge.
  - pass, table_out, mismatch_cnt and first_fail_* are valid in the done cycle and hold until the next accepted start or reset.
- Counter width: mismatch_cnt is 5 bits and saturation is never needed (max 16). The vector index wraps 15->0 only on a new start, never inside a sweep.
- start while busy or in DONE is ignored. No restart and no queuing; start is not latched.
- start held high continuously: a new sweep begins on the first IDLE cycle after DONE. Back-to-back sweeps are separated by exactly one IDLE cycle.
- rst mid-sweep takes priority over all other activity: the next cycle is IDLE with reset values and done is not pulsed.
- Outputs A..D change only on the SAMPLE->SETTLE transition or the IDLE->SETTLE transition. They never glitch during a hold window.

Test Plan:
1. Reset, then start for 1 cycle with F wired to A&~B | ~C&D, default params -> vectors 0..15 in order, each held 2 cycles; done pulse 32 cycles after start; table_out=16'h2F22, mismatch_cnt=0, pass=1, first_fail_valid=0.
2. F tied 0 -> table_out=16'h0000, mismatch_cnt=7, first_fail_idx=1, first_fail_valid=1, pass=0.
3. F tied 1 -> table_out=16'hFFFF, mismatch_cnt=9, first_fail_idx=0, pass=0.
4. Correct F with SETTLE_CYCLES=3 -> each vector held 4 cycles; done 64 cycles after start; pass=1. A second start pulse at cycle 10 is ignored: busy stays 1 and only one done pulse occurs.
5. rst asserted at vector 6 -> next cycle busy=0, A..D=0, table_out=0, no done. A subsequent start yields a full clean sweep with pass=1.
6. start held high across two sweeps, first with F tied 0 and then with correct F -> the second sweep's clear is visible after one IDLE cycle; final table_out=16'h2F22, mismatch_cnt=0, pass=1.
